// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge: controller states,
// HRESP/HTRANS codes and the one-hot APB slave selects.
package apb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WWAIT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_e;

    localparam logic [1:0] HRESP_OKAY   = 2'b00;
    localparam logic [1:0] HRESP_ERROR  = 2'b01;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_S0   = 3'b001;
    localparam logic [2:0] SEL_S1   = 3'b010;
    localparam logic [2:0] SEL_S2   = 3'b100;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on pready; expired_o flags the last
// permitted wait cycle. With TIMEOUT=0 the counter never moves and never expires.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (TIMEOUT != 0))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign expired_o = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/apb_controller.sv
// APB-side engine of the AHB-to-APB bridge: runs SETUP/ACCESS for each qualified
// AHB transfer and returns hreadyout/hresp/hrdata, including the two-cycle ERROR.
module apb_controller
    import apb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              valid,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [2:0]        temp_selx,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic [2:0]        psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              hreadyout,
    output logic [1:0]        hresp,
    output logic [DATA_W-1:0] hrdata
);

    state_e            state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;
    logic              timer_clr, timer_en, timer_exp;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i     (hclk),
        .rst_ni    (hresetn),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_exp)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        hrdata_d  = hrdata_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state_q)
            // ERR2 completes an address phase just like IDLE does
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (valid) begin
                    paddr_d  = haddr;
                    pwrite_d = hwrite;
                    sel_d    = temp_selx;
                    if (temp_selx == SEL_NONE) state_d = ST_ERR1;
                    else if (hwrite)           state_d = ST_WWAIT;
                    else                       state_d = ST_SETUP;
                end
            end
            ST_WWAIT: begin
                pwdata_d = hwdata;
                state_d  = ST_SETUP;
            end
            ST_SETUP: begin
                timer_clr = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    if (!pwrite_q) hrdata_d = prdata;
                    state_d = pslverr ? ST_ERR1 : ST_IDLE;
                end else begin
                    timer_en = 1'b1;
                    if (timer_exp) state_d = ST_ERR1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= ST_IDLE;
            sel_q    <= SEL_NONE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            hrdata_q <= hrdata_d;
        end
    end

    // Decoded from state so an async reset drops psel/penable immediately
    assign psel      = (state_q == ST_SETUP || state_q == ST_ACCESS) ? sel_q : SEL_NONE;
    assign penable   = (state_q == ST_ACCESS);
    assign hreadyout = (state_q == ST_IDLE || state_q == ST_ERR2);
    assign hresp     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign hrdata    = hrdata_q;

endmodule
